// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and helpers for the feature staging path
package qracc_pkg;

    typedef enum logic [1:0] {FU_IDLE, FU_SEND, FU_DONE} fu_state_t;

    localparam int FU_IDXW = 10;

    function automatic int fu_epw(input int out_w, input int elem_w);
        return out_w / elem_w;
    endfunction

endpackage

// File: rtl/feature_word_packer.sv
// feature_word_packer: builds one output word and its strobes from the snapshot window
module feature_word_packer import qracc_pkg::*; #(
    parameter int outputWidth  = 256,
    parameter int elementWidth = 8,
    parameter int numElements  = 128
) (
    input  logic [numElements-1:0][elementWidth-1:0]   snap_i,
    input  logic [FU_IDXW-1:0]                          base_i,
    input  logic [FU_IDXW-1:0]                          end_i,
    output logic [outputWidth-1:0]                      data_o,
    output logic [fu_epw(outputWidth, elementWidth)-1:0] strb_o
);

    localparam int EPW = fu_epw(outputWidth, elementWidth);
    localparam int IW  = $clog2(numElements);

    for (genvar i = 0; i < EPW; i++) begin : g_slot
        logic [FU_IDXW-1:0] e;
        logic en;
        assign e  = base_i + FU_IDXW'(i);
        assign en = e < end_i;
        assign strb_o[EPW-1-i] = en;
        assign data_o[(EPW-1-i)*elementWidth +: elementWidth] = en ? snap_i[e[IW-1:0]] : '0;
    end

endmodule

// File: rtl/feature_unloader.sv
// feature_unloader: snapshots an element array and streams a window of it as packed write words
module feature_unloader import qracc_pkg::*; #(
    parameter int outputWidth  = 256,
    parameter int addrWidth    = 8,
    parameter int elementWidth = 8,
    parameter int numElements  = 128
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [numElements-1:0][elementWidth-1:0]     data_i,
    input  logic                                         start_i,
    input  logic [FU_IDXW-1:0]                           elem_start_i,
    input  logic [FU_IDXW-1:0]                           elem_end_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic [outputWidth-1:0]                       wr_data_o,
    output logic [addrWidth-1:0]                         wr_addr_o,
    output logic [fu_epw(outputWidth, elementWidth)-1:0] wr_strb_o,
    output logic                                         wr_valid_o,
    input  logic                                         wr_ready_i,
    output logic                                         wr_last_o
);

    localparam int EPW = fu_epw(outputWidth, elementWidth);
    localparam logic [FU_IDXW-1:0] NE = FU_IDXW'(numElements);

    fu_state_t                              state;
    logic [numElements-1:0][elementWidth-1:0] snap;
    logic [FU_IDXW-1:0]                     base;
    logic [FU_IDXW-1:0]                     end_q;
    logic [FU_IDXW-1:0]                     end_n;
    logic                                   last_n;
    logic [outputWidth-1:0]                 pk_data;
    logic [EPW-1:0]                         pk_strb;

    assign end_n     = elem_end_i > NE ? NE : elem_end_i;
    assign last_n    = base + FU_IDXW'(EPW) >= end_q;
    assign wr_data_o = wr_valid_o ? pk_data : '0;
    assign wr_strb_o = wr_valid_o ? pk_strb : '0;
    assign wr_last_o = wr_valid_o & last_n;
    assign wr_addr_o = base[addrWidth-1:0];

    feature_word_packer #(
        .outputWidth  (outputWidth),
        .elementWidth (elementWidth),
        .numElements  (numElements)
    ) u_packer (
        .snap_i (snap),
        .base_i (base),
        .end_i  (end_q),
        .data_o (pk_data),
        .strb_o (pk_strb)
    );

    // Transfer sequencing: capture window on start, advance one word per handshake, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FU_IDLE;
            snap       <= '0;
            base       <= '0;
            end_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            wr_valid_o <= 1'b0;
        end else begin
            case (state)
                FU_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        snap   <= data_i;
                        base   <= elem_start_i;
                        end_q  <= end_n;
                        busy_o <= 1'b1;
                        if (elem_start_i >= end_n) begin
                            state  <= FU_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= FU_SEND;
                            wr_valid_o <= 1'b1;
                        end
                    end
                end
                FU_SEND: begin
                    if (wr_ready_i) begin
                        base <= base + FU_IDXW'(EPW);
                        if (last_n) begin
                            wr_valid_o <= 1'b0;
                            done_o     <= 1'b1;
                            state      <= FU_DONE;
                        end
                    end
                end
                default: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= FU_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_unloader.sv
// tb_feature_unloader: randomized scenario bench against a window/packing reference model
module tb_feature_unloader;

    typedef logic [127:0][7:0] snap_t;
    typedef struct packed {
        logic [255:0] d;
        logic [7:0]   a;
        logic [31:0]  s;
        logic         l;
    } word_t;
    typedef struct {
        word_t w;
        logic  r;
        int    c;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    snap_t        data_i = '0;
    logic         start_i = 1'b0;
    logic [9:0]   elem_start_i = '0;
    logic [9:0]   elem_end_i = '0;
    logic         busy_o, done_o, wr_valid_o, wr_last_o;
    logic         wr_ready_i = 1'b0;
    logic [255:0] wr_data_o;
    logic [7:0]   wr_addr_o;
    logic [31:0]  wr_strb_o;

    int   tests = 0;
    int   fails = 0;
    obs_t obs[$];
    logic busy_log[$];
    int   done_cyc;
    int   done_cnt;

    always #5 clk = ~clk;

    feature_unloader dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .start_i      (start_i),
        .elem_start_i (elem_start_i),
        .elem_end_i   (elem_end_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .wr_data_o    (wr_data_o),
        .wr_addr_o    (wr_addr_o),
        .wr_strb_o    (wr_strb_o),
        .wr_valid_o   (wr_valid_o),
        .wr_ready_i   (wr_ready_i),
        .wr_last_o    (wr_last_o)
    );

    function automatic snap_t rand_snap();
        snap_t v;
        for (int i = 0; i < 128; i++) v[i] = 8'($urandom);
        return v;
    endfunction

    function automatic int clip_end(input int e);
        return e > 128 ? 128 : e;
    endfunction

    function automatic int nwords(input int s, input int e);
        int ee = clip_end(e);
        return s >= ee ? 0 : (ee - s + 31) / 32;
    endfunction

    // Word k of window [s, e): element s+32k+i lands in slot i, MSB-first
    function automatic word_t exp_word(input snap_t sn, input int s, input int e, input int k);
        word_t w;
        int ee = clip_end(e);
        int b = s + k * 32;
        w = '0;
        w.a = 8'(b);
        for (int i = 0; i < 32; i++) begin
            if (b + i < ee) begin
                w.d[(31-i)*8 +: 8] = sn[b+i];
                w.s[31-i] = 1'b1;
            end
        end
        w.l = (b + 32 >= ee);
        return w;
    endfunction

    task automatic run_xfer(input int s, input int e, input snap_t sn, input int stall, input bit rnd, input bit poke);
        obs_t o;
        obs.delete();
        busy_log.delete();
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk);
        data_i = sn;
        elem_start_i = 10'(s);
        elem_end_i = 10'(e);
        start_i = 1'b1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_i = 1'b0;
                data_i = rand_snap();
            end
            if (poke && cyc == 2) begin
                start_i = 1'b1;
                elem_start_i = 10'd0;
                elem_end_i = 10'd20;
                data_i = rand_snap();
            end
            if (poke && cyc == 3) start_i = 1'b0;
            wr_ready_i = rnd ? ($urandom_range(0, 3) != 0) : (cyc > stall);
            busy_log.push_back(busy_o);
            if (wr_valid_o) begin
                o.w = {wr_data_o, wr_addr_o, wr_strb_o, wr_last_o};
                o.r = wr_ready_i;
                o.c = cyc;
                obs.push_back(o);
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        wr_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({busy_o, done_o, wr_valid_o, wr_last_o} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got busy/done/valid/last=%b, expected 0000", {busy_o, done_o, wr_valid_o, wr_last_o});
        end
        tests++;
        if ({wr_data_o, wr_addr_o, wr_strb_o} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got addr=%0h strb=%h data=%h, expected all zero", wr_addr_o, wr_strb_o, wr_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy_o, done_o, wr_valid_o} !== 3'b0) begin
            fails++;
            $display("FAIL reset_release: got busy/done/valid=%b, expected 000", {busy_o, done_o, wr_valid_o});
        end
    endtask

    task automatic test_full();
        snap_t sn = rand_snap();
        int hs = 0;
        int ones = 0;
        run_xfer(0, 128, sn, 0, 1'b0, 1'b0);
        foreach (obs[j]) begin
            tests++;
            if (obs[j].w !== exp_word(sn, 0, 128, hs) || obs[j].c !== hs + 1) begin
                fails++;
                $display("FAIL full_word%0d: got cyc=%0d addr=%0h strb=%h last=%b, expected cyc=%0d addr=%0h strb=%h last=%b",
                         hs, obs[j].c, obs[j].w.a, obs[j].w.s, obs[j].w.l, hs + 1,
                         exp_word(sn, 0, 128, hs).a, exp_word(sn, 0, 128, hs).s, exp_word(sn, 0, 128, hs).l);
            end
            hs++;
        end
        tests++;
        if (hs !== 4) begin fails++; $display("FAIL full_count: got %0d words, expected 4", hs); end
        tests++;
        if (done_cyc !== 5 || done_cnt !== 1) begin
            fails++;
            $display("FAIL full_done: got done at cycle %0d x%0d, expected cycle 5 x1", done_cyc, done_cnt);
        end
        foreach (busy_log[j]) ones += int'(busy_log[j]);
        tests++;
        if (ones !== 5 || busy_log[5] !== 1'b0) begin
            fails++;
            $display("FAIL full_busy: got %0d busy cycles, expected 5 ending after done", ones);
        end
    endtask

    task automatic test_partial();
        snap_t sn = rand_snap();
        int hs = 0;
        run_xfer(5, 40, sn, 0, 1'b0, 1'b0);
        foreach (obs[j]) begin
            tests++;
            if (obs[j].w !== exp_word(sn, 5, 40, hs)) begin
                fails++;
                $display("FAIL partial_word%0d: got addr=%0h strb=%h last=%b data=%h, expected addr=%0h strb=%h last=%b data=%h",
                         hs, obs[j].w.a, obs[j].w.s, obs[j].w.l, obs[j].w.d, exp_word(sn, 5, 40, hs).a,
                         exp_word(sn, 5, 40, hs).s, exp_word(sn, 5, 40, hs).l, exp_word(sn, 5, 40, hs).d);
            end
            hs++;
        end
        tests++;
        if (hs !== 2) begin fails++; $display("FAIL partial_count: got %0d words, expected 2", hs); end
        if (hs == 2) begin
            tests++;
            if ({obs[0].w.a, obs[0].w.s, obs[1].w.a, obs[1].w.s, obs[1].w.l} !== {8'd5, 32'hFFFF_FFFF, 8'd37, 32'hE000_0000, 1'b1}) begin
                fails++;
                $display("FAIL partial_strb: got %0h/%h %0h/%h last=%b, expected 5/ffffffff 25/e0000000 last=1",
                         obs[0].w.a, obs[0].w.s, obs[1].w.a, obs[1].w.s, obs[1].w.l);
            end
        end
    endtask

    task automatic test_stall();
        snap_t sn = rand_snap();
        int hs = 0;
        run_xfer(0, 128, sn, 3, 1'b0, 1'b0);
        tests++;
        if (obs.size() !== 7) begin fails++; $display("FAIL stall_valid_cycles: got %0d, expected 7", obs.size()); end
        for (int j = 0; j < 3 && j < obs.size(); j++) begin
            tests++;
            if (obs[j].w !== exp_word(sn, 0, 128, 0) || obs[j].r !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: got addr=%0h strb=%h ready=%b, expected addr=0 strb=ffffffff ready=0",
                         j, obs[j].w.a, obs[j].w.s, obs[j].r);
            end
        end
        foreach (obs[j]) begin
            if (obs[j].r) begin
                tests++;
                if (obs[j].w !== exp_word(sn, 0, 128, hs)) begin
                    fails++;
                    $display("FAIL stall_word%0d: got addr=%0h strb=%h last=%b, expected addr=%0h",
                             hs, obs[j].w.a, obs[j].w.s, obs[j].w.l, exp_word(sn, 0, 128, hs).a);
                end
                hs++;
            end
        end
        tests++;
        if (hs !== 4 || done_cyc !== 8) begin
            fails++;
            $display("FAIL stall_count: got %0d words done at %0d, expected 4 words done at 8", hs, done_cyc);
        end
    endtask

    task automatic test_empty();
        int win[2][2] = '{'{10, 10}, '{130, 200}};
        for (int t = 0; t < 2; t++) begin
            run_xfer(win[t][0], win[t][1], rand_snap(), 0, 1'b0, 1'b0);
            tests++;
            if (obs.size() !== 0 || done_cyc !== 1 || done_cnt !== 1) begin
                fails++;
                $display("FAIL empty%0d: got %0d valid cycles, done at %0d x%0d, expected 0 valid, done at 1 x1",
                         t, obs.size(), done_cyc, done_cnt);
            end
        end
    endtask

    task automatic test_ignore_start();
        snap_t sn = rand_snap();
        int hs = 0;
        run_xfer(3, 100, sn, 0, 1'b0, 1'b1);
        foreach (obs[j]) begin
            tests++;
            if (obs[j].w !== exp_word(sn, 3, 100, hs)) begin
                fails++;
                $display("FAIL ignore_word%0d: got addr=%0h strb=%h data=%h, expected addr=%0h strb=%h data=%h",
                         hs, obs[j].w.a, obs[j].w.s, obs[j].w.d, exp_word(sn, 3, 100, hs).a,
                         exp_word(sn, 3, 100, hs).s, exp_word(sn, 3, 100, hs).d);
            end
            hs++;
        end
        tests++;
        if (hs !== 4 || done_cnt !== 1 || busy_log[busy_log.size()-1] !== 1'b0) begin
            fails++;
            $display("FAIL ignore_count: got %0d words done x%0d, expected 4 words done x1 then idle", hs, done_cnt);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            snap_t sn = rand_snap();
            int s = $urandom_range(0, 140);
            int e = $urandom_range(0, 200);
            int hs = 0;
            run_xfer(s, e, sn, 0, 1'b1, 1'b0);
            foreach (obs[j]) begin
                if (obs[j].r) begin
                    tests++;
                    if (obs[j].w !== exp_word(sn, s, e, hs)) begin
                        fails++;
                        $display("FAIL random%0d_word%0d [%0d,%0d): got addr=%0h strb=%h last=%b, expected addr=%0h strb=%h last=%b",
                                 t, hs, s, e, obs[j].w.a, obs[j].w.s, obs[j].w.l, exp_word(sn, s, e, hs).a,
                                 exp_word(sn, s, e, hs).s, exp_word(sn, s, e, hs).l);
                    end
                    hs++;
                end
            end
            tests++;
            if (hs !== nwords(s, e) || done_cnt !== 1) begin
                fails++;
                $display("FAIL random%0d_count [%0d,%0d): got %0d words done x%0d, expected %0d words done x1",
                         t, s, e, hs, done_cnt, nwords(s, e));
            end
        end
    endtask

    task automatic test_rst_mid();
        snap_t sn = rand_snap();
        int hs = 0;
        @(negedge clk);
        data_i = sn;
        elem_start_i = 10'd0;
        elem_end_i = 10'd128;
        start_i = 1'b1;
        wr_ready_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (wr_valid_o !== 1'b1 || wr_addr_o !== 8'd64) begin
            fails++;
            $display("FAIL rst_mid_pre: got valid=%b addr=%0h, expected valid=1 addr=40", wr_valid_o, wr_addr_o);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({wr_valid_o, busy_o, done_o} !== 3'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: got valid/busy/done=%b, expected 000", {wr_valid_o, busy_o, done_o});
        end
        wr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sn = rand_snap();
        run_xfer(0, 128, sn, 0, 1'b0, 1'b0);
        foreach (obs[j]) begin
            tests++;
            if (obs[j].w !== exp_word(sn, 0, 128, hs)) begin
                fails++;
                $display("FAIL rst_mid_word%0d: got addr=%0h strb=%h, expected addr=%0h strb=%h",
                         hs, obs[j].w.a, obs[j].w.s, exp_word(sn, 0, 128, hs).a, exp_word(sn, 0, 128, hs).s);
            end
            hs++;
        end
        tests++;
        if (hs !== 4 || done_cyc !== 5) begin
            fails++;
            $display("FAIL rst_mid_rerun: got %0d words done at %0d, expected 4 words done at 5", hs, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_stall();
        test_empty();
        test_ignore_start();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
